// File: rtl/riscv_mc_ctrl.sv
// Multicycle RV32I control unit: fetch/decode/execute/memory/writeback sequencing,
// memory wait-state watchdog and sticky trap. Define RV_MC_BNE_EN to accept bne.
module riscv_mc_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 16,
  parameter int unsigned CNT_W          = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       Zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       MemWrite,
  output logic       AdrSrc,
  output logic       IRWrite,
  output logic       PCWrite,
  output logic       RegWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ImmSrc,
  output logic [2:0] ALUControl,
  output logic       trap,
  output logic [1:0] trap_cause,
  output logic [3:0] state_o
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9,
    S_JAL      = 4'd10,
    S_TRAP     = 4'd15
  } state_e;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_IALU   = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
  localparam logic [1:0] CAUSE_TIMEOUT = 2'b10;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       cause_q, cause_d;

  logic       mem_req_c, mem_write_c, adr_src_c, ir_write_c, pc_write_c, reg_write_c;
  logic [1:0] result_src_c, src_a_c, src_b_c, alu_op_c, imm_src_c;
  logic [2:0] alu_ctrl_c;
  logic       alu_legal_c, br_legal_c, br_take_c, mem_wait_c;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= S_FETCH;
      cnt_q   <= '0;
      cause_q <= 2'b00;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cause_q <= cause_d;
    end
  end

  // ALU function decode and legality of the funct3 field
  always_comb begin
    alu_ctrl_c  = 3'b000;
    alu_legal_c = 1'b1;
    case (alu_op_c)
      2'b00: alu_ctrl_c = 3'b000;
      2'b01: alu_ctrl_c = 3'b001;
      default: begin
        case (funct3)
          3'b000:  alu_ctrl_c = (funct7b5 & op[5]) ? 3'b001 : 3'b000;
          3'b010:  alu_ctrl_c = 3'b101;
          3'b110:  alu_ctrl_c = 3'b011;
          3'b111:  alu_ctrl_c = 3'b010;
          default: alu_legal_c = 1'b0;
        endcase
      end
    endcase
  end

  always_comb begin
    case (op)
      OP_STORE:  imm_src_c = 2'b01;
      OP_BRANCH: imm_src_c = 2'b10;
      OP_JAL:    imm_src_c = 2'b11;
      default:   imm_src_c = 2'b00;
    endcase
  end

`ifdef RV_MC_BNE_EN
  assign br_legal_c = (funct3 == 3'b000) || (funct3 == 3'b001);
  assign br_take_c  = (funct3 == 3'b001) ? ~Zero : Zero;
`else
  assign br_legal_c = (funct3 == 3'b000);
  assign br_take_c  = Zero;
`endif

  assign mem_wait_c = ((state_q == S_FETCH) || (state_q == S_MEMREAD) ||
                       (state_q == S_MEMWRITE)) && !mem_ready;

  // Next-state and per-state control decode
  always_comb begin
    state_d      = state_q;
    cause_d      = cause_q;
    cnt_d        = cnt_q;
    mem_req_c    = 1'b0;
    mem_write_c  = 1'b0;
    adr_src_c    = 1'b0;
    ir_write_c   = 1'b0;
    pc_write_c   = 1'b0;
    reg_write_c  = 1'b0;
    result_src_c = 2'b00;
    src_a_c      = 2'b00;
    src_b_c      = 2'b00;
    alu_op_c     = 2'b00;

    case (state_q)
      S_FETCH: begin
        mem_req_c    = 1'b1;
        src_b_c      = 2'b10;
        result_src_c = 2'b10;
        if (mem_ready) begin
          ir_write_c = 1'b1;
          pc_write_c = 1'b1;
          state_d    = S_DECODE;
        end
      end
      S_DECODE: begin
        src_a_c = 2'b01;
        src_b_c = 2'b01;
        case (op)
          OP_LOAD, OP_STORE: state_d = S_MEMADR;
          OP_RTYPE:          state_d = S_EXECR;
          OP_IALU:           state_d = S_EXECI;
          OP_JAL:            state_d = S_JAL;
          OP_BRANCH: begin
            if (br_legal_c) begin
              state_d = S_BRANCH;
            end else begin
              state_d = S_TRAP;
              cause_d = CAUSE_ILLEGAL;
            end
          end
          default: begin
            state_d = S_TRAP;
            cause_d = CAUSE_ILLEGAL;
          end
        endcase
      end
      S_MEMADR: begin
        src_a_c = 2'b10;
        src_b_c = 2'b01;
        state_d = (op == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        mem_req_c = 1'b1;
        adr_src_c = 1'b1;
        if (mem_ready) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        result_src_c = 2'b01;
        reg_write_c  = 1'b1;
        state_d      = S_FETCH;
      end
      S_MEMWRITE: begin
        mem_req_c   = 1'b1;
        mem_write_c = 1'b1;
        adr_src_c   = 1'b1;
        if (mem_ready) state_d = S_FETCH;
      end
      S_EXECR, S_EXECI: begin
        src_a_c  = 2'b10;
        src_b_c  = (state_q == S_EXECI) ? 2'b01 : 2'b00;
        alu_op_c = 2'b10;
        if (alu_legal_c) begin
          state_d = S_ALUWB;
        end else begin
          state_d = S_TRAP;
          cause_d = CAUSE_ILLEGAL;
        end
      end
      S_ALUWB: begin
        reg_write_c = 1'b1;
        state_d     = S_FETCH;
      end
      S_BRANCH: begin
        src_a_c    = 2'b10;
        alu_op_c   = 2'b01;
        pc_write_c = br_take_c;
        state_d    = S_FETCH;
      end
      S_JAL: begin
        src_a_c    = 2'b01;
        src_b_c    = 2'b10;
        pc_write_c = 1'b1;
        state_d    = S_ALUWB;
      end
      S_TRAP: state_d = S_TRAP;
      default: state_d = S_FETCH;
    endcase

    // Watchdog: the last tolerated not-ready cycle without completion traps
    if (mem_wait_c && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1))) begin
      state_d = S_TRAP;
      cause_d = CAUSE_TIMEOUT;
    end

    if (state_d != state_q) begin
      cnt_d = '0;
    end else if (mem_wait_c) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Write enables are suppressed while reset is asserted
  assign mem_req    = mem_req_c;
  assign MemWrite   = mem_write_c & reset_n;
  assign AdrSrc     = adr_src_c;
  assign IRWrite    = ir_write_c & reset_n;
  assign PCWrite    = pc_write_c & reset_n;
  assign RegWrite   = reg_write_c & reset_n;
  assign ResultSrc  = result_src_c;
  assign ALUSrcA    = src_a_c;
  assign ALUSrcB    = src_b_c;
  assign ImmSrc     = imm_src_c;
  assign ALUControl = alu_ctrl_c;
  assign trap       = (state_q == S_TRAP);
  assign trap_cause = cause_q;
  assign state_o    = state_q;

endmodule

// File: tb/tb_riscv_mc_ctrl.sv
// Scoreboard bench for riscv_mc_ctrl: instruction-level traces are expanded into
// per-cycle expectations, and a negedge monitor compares them with the DUT outputs.
module tb_riscv_mc_ctrl;
  localparam int unsigned T = 4;

  localparam logic [3:0] ST_FETCH = 4'd0, ST_DECODE = 4'd1, ST_MEMADR = 4'd2,
                         ST_MEMREAD = 4'd3, ST_MEMWB = 4'd4, ST_MEMWRITE = 4'd5,
                         ST_EXECR = 4'd6, ST_EXECI = 4'd7, ST_ALUWB = 4'd8,
                         ST_BRANCH = 4'd9, ST_JAL = 4'd10, ST_TRAP = 4'd15;

  localparam logic [6:0] LW = 7'b0000011, SW = 7'b0100011, RT = 7'b0110011,
                         IA = 7'b0010011, BR = 7'b1100011, JL = 7'b1101111;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [6:0] op = LW;
  logic [2:0] funct3 = 3'b000;
  logic       funct7b5 = 1'b0;
  logic       Zero = 1'b0;
  logic       mem_ready = 1'b0;
  logic       mem_req, MemWrite, AdrSrc, IRWrite, PCWrite, RegWrite, trap;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, trap_cause;
  logic [2:0] ALUControl;
  logic [3:0] state_o;

  riscv_mc_ctrl #(.TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .reset_n(reset_n), .op(op), .funct3(funct3), .funct7b5(funct7b5),
    .Zero(Zero), .mem_ready(mem_ready), .mem_req(mem_req), .MemWrite(MemWrite),
    .AdrSrc(AdrSrc), .IRWrite(IRWrite), .PCWrite(PCWrite), .RegWrite(RegWrite),
    .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ImmSrc(ImmSrc),
    .ALUControl(ALUControl), .trap(trap), .trap_cause(trap_cause), .state_o(state_o)
  );

  initial forever #5 clk = ~clk;

  typedef struct packed {
    logic       rst_n;
    logic       rdy;
    logic       zero;
    logic [6:0] op;
    logic [2:0] f3;
    logic       f7;
    logic [3:0] st;
    logic [1:0] cause;
  } step_t;

  step_t       plan[$];
  logic [23:0] exp_q[$];
  int          total = 0;
  int          bad = 0;

  logic [6:0] cur_op;
  logic [2:0] cur_f3;
  logic       cur_f7, cur_zero;
  bit         in_trap = 0;
  logic [1:0] cause_m = 2'b00;
  int         abort_at = -1;
  int         emit_n = 0;
  bit         aborted = 0;

  function automatic logic [2:0] exec_alu(step_t s);
    case (s.f3)
      3'd0:    return (s.f7 && s.op[5]) ? 3'b001 : 3'b000;
      3'd2:    return 3'b101;
      3'd6:    return 3'b011;
      3'd7:    return 3'b010;
      default: return 3'b000;
    endcase
  endfunction

  // Required outputs for one cycle, from the per-state output table
  function automatic logic [23:0] expect_vec(step_t s);
    logic mreq = 0, mw = 0, adr = 0, irw = 0, pcw = 0, rw = 0;
    logic [1:0] rs = 0, sa = 0, sb = 0, imm;
    logic [2:0] alu = 0;
    case (s.op)
      SW: imm = 2'b01;
      BR: imm = 2'b10;
      JL: imm = 2'b11;
      default: imm = 2'b00;
    endcase
    case (s.st)
      ST_FETCH:    begin mreq = 1; sb = 2; rs = 2; irw = s.rdy; pcw = s.rdy; end
      ST_DECODE:   begin sa = 1; sb = 1; end
      ST_MEMADR:   begin sa = 2; sb = 1; end
      ST_MEMREAD:  begin mreq = 1; adr = 1; end
      ST_MEMWB:    begin rs = 1; rw = 1; end
      ST_MEMWRITE: begin mreq = 1; mw = 1; adr = 1; end
      ST_EXECR:    begin sa = 2; sb = 0; alu = exec_alu(s); end
      ST_EXECI:    begin sa = 2; sb = 1; alu = exec_alu(s); end
      ST_ALUWB:    begin rw = 1; end
      ST_BRANCH:   begin sa = 2; alu = 3'b001; pcw = (s.f3 == 3'd1) ? ~s.zero : s.zero; end
      ST_JAL:      begin sa = 1; sb = 2; pcw = 1; end
      default: ;
    endcase
    if (!s.rst_n) begin mw = 0; irw = 0; pcw = 0; rw = 0; end
    return {s.st, mreq, mw, adr, irw, pcw, rw, rs, sa, sb, imm, alu,
            (s.st == ST_TRAP), s.cause};
  endfunction

  task automatic emit(input logic [3:0] st, input logic rdy);
    step_t s;
    if (aborted) return;
    s.rst_n = (emit_n == abort_at) ? 1'b0 : 1'b1;
    s.rdy = rdy; s.zero = cur_zero; s.op = cur_op; s.f3 = cur_f3; s.f7 = cur_f7;
    s.st = st; s.cause = cause_m;
    plan.push_back(s);
    if (emit_n == abort_at) aborted = 1;
    emit_n++;
  endtask

  task automatic raise(input logic [1:0] c);
    if (!aborted) begin in_trap = 1; cause_m = c; end
  endtask

  // A memory state with w not-ready cycles before ready; too many waits trap
  task automatic mem_phase(input logic [3:0] st, input int w, output bit ok);
    ok = 0;
    for (int i = 0; i < w && i < int'(T); i++) emit(st, 1'b0);
    if (w >= int'(T)) raise(2'b10);
    else begin emit(st, 1'b1); ok = 1; end
    if (aborted) ok = 0;
  endtask

  task automatic body(input int wf, input int wm);
    bit ok;
    mem_phase(ST_FETCH, wf, ok);
    if (!ok) return;
    emit(ST_DECODE, 1'($urandom_range(0, 1)));
    case (cur_op)
      LW: begin
        emit(ST_MEMADR, 1'($urandom_range(0, 1)));
        mem_phase(ST_MEMREAD, wm, ok);
        if (ok) emit(ST_MEMWB, 1'($urandom_range(0, 1)));
      end
      SW: begin
        emit(ST_MEMADR, 1'($urandom_range(0, 1)));
        mem_phase(ST_MEMWRITE, wm, ok);
      end
      RT, IA: begin
        emit((cur_op == RT) ? ST_EXECR : ST_EXECI, 1'($urandom_range(0, 1)));
        if (cur_f3 inside {3'd0, 3'd2, 3'd6, 3'd7}) emit(ST_ALUWB, 1'($urandom_range(0, 1)));
        else raise(2'b01);
      end
      BR: begin
`ifdef RV_MC_BNE_EN
        if (cur_f3 == 3'd0 || cur_f3 == 3'd1) emit(ST_BRANCH, 1'($urandom_range(0, 1)));
`else
        if (cur_f3 == 3'd0) emit(ST_BRANCH, 1'($urandom_range(0, 1)));
`endif
        else raise(2'b01);
      end
      JL: begin
        emit(ST_JAL, 1'($urandom_range(0, 1)));
        emit(ST_ALUWB, 1'($urandom_range(0, 1)));
      end
      default: raise(2'b01);
    endcase
  endtask

  task automatic do_reset(input logic [3:0] st, input logic rdy);
    step_t s;
    s.rst_n = 1'b0; s.rdy = rdy; s.zero = cur_zero; s.op = cur_op; s.f3 = cur_f3;
    s.f7 = cur_f7; s.st = st; s.cause = cause_m;
    plan.push_back(s);
    in_trap = 0; cause_m = 2'b00;
  endtask

  task automatic recover();
    if (in_trap) begin
      abort_at = -1; aborted = 0;
      for (int i = 0; i < int'($urandom_range(1, 4)); i++) emit(ST_TRAP, 1'($urandom_range(0, 1)));
      do_reset(ST_TRAP, 1'($urandom_range(0, 1)));
    end
  endtask

  task automatic instr(input logic [6:0] o, input logic [2:0] f3, input logic f7,
                       input logic z, input int wf, input int wm, input int ab);
    cur_op = o; cur_f3 = f3; cur_f7 = f7; cur_zero = z;
    aborted = 0; emit_n = 0; abort_at = ab;
    body(wf, wm);
    if (aborted) begin in_trap = 0; cause_m = 2'b00; end
  endtask

  function automatic logic [6:0] pick_op();
    logic [6:0] ops [6] = '{LW, SW, RT, IA, BR, JL};
    logic [6:0] o;
    if ($urandom_range(0, 9) != 0) return ops[$urandom_range(0, 5)];
    do o = 7'($urandom); while (o inside {LW, SW, RT, IA, BR, JL});
    return o;
  endfunction

  initial begin : monitor
    logic [23:0] e, got;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        got = {state_o, mem_req, MemWrite, AdrSrc, IRWrite, PCWrite, RegWrite, ResultSrc,
               ALUSrcA, ALUSrcB, ImmSrc, ALUControl, trap, trap_cause};
        total++;
        if (got !== e) begin
          bad++;
          $display("FAIL ctrl_out t=%0t got=%h required=%h (state got %0d required %0d)",
                   $time, got, e, got[23:20], e[23:20]);
        end
      end
    end
  end

  initial begin : stim
    logic [2:0] legal_f3 [4] = '{3'd0, 3'd2, 3'd6, 3'd7};
    cur_op = LW; cur_f3 = 3'd2; cur_f7 = 1'b0; cur_zero = 1'b0;
    do_reset(ST_FETCH, 1'b1);
    instr(LW, 3'd2, 0, 0, 0, 0, -1);
    instr(SW, 3'd2, 0, 0, 0, 3, -1);
    instr(BR, 3'd0, 0, 1, 0, 0, -1);
    instr(BR, 3'd0, 0, 0, 0, 0, -1);
    instr(7'h00, 3'd0, 0, 0, 0, 0, -1);
    aborted = 0; abort_at = -1;
    for (int i = 0; i < 20; i++) emit(ST_TRAP, 1'($urandom_range(0, 1)));
    do_reset(ST_TRAP, 1'b1);
    instr(RT, 3'd0, 1, 0, 4, 0, -1);
    recover();
    instr(RT, 3'd0, 1, 0, 3, 0, -1);
    instr(BR, 3'd1, 0, 0, 0, 0, -1);
    recover();
    instr(RT, 3'd7, 0, 0, 0, 0, 2);
    instr(IA, 3'd0, 1, 0, 0, 0, -1);
    instr(JL, 3'd0, 0, 0, 1, 0, -1);
    instr(LW, 3'd2, 0, 0, 0, 3, 5);
    for (int n = 0; n < 200; n++) begin
      logic [6:0] o;
      logic [2:0] f3;
      int wf, wm, ab;
      o  = pick_op();
      f3 = ($urandom_range(0, 4) != 0) ? legal_f3[$urandom_range(0, 3)] : 3'($urandom);
      if (o == BR) f3 = ($urandom_range(0, 3) != 0) ? 3'($urandom_range(0, 1)) : 3'($urandom);
      wf = ($urandom_range(0, 19) == 0) ? int'($urandom_range(3, 5)) : int'($urandom_range(0, 2));
      wm = ($urandom_range(0, 19) == 0) ? int'($urandom_range(3, 5)) : int'($urandom_range(0, 2));
      ab = ($urandom_range(0, 19) == 0) ? int'($urandom_range(0, 6)) : -1;
      instr(o, f3, 1'($urandom), 1'($urandom), wf, wm, ab);
      recover();
    end

    @(posedge clk);
    foreach (plan[i]) begin
      @(posedge clk);
      #1;
      reset_n   = plan[i].rst_n;
      mem_ready = plan[i].rdy;
      Zero      = plan[i].zero;
      op        = plan[i].op;
      funct3    = plan[i].f3;
      funct7b5  = plan[i].f7;
      exp_q.push_back(expect_vec(plan[i]));
    end
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain pending=%0d required=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
